serdes_trigger_word_receiver: RTL and testbench
===============================================

# serdes_trigger_word_receiver

Receiving end of the 8-bit serialized trigger-word link. It takes parallel words from an upstream 1:8 input deserializer and finds the bit offset of the transmitted words. It then decodes the four trigger tokens (F0, 81, 88, AA, idle 00) into single-cycle trigger/sync pulses with a token id. It sits in the fabric clock domain directly after the deserializer and feeds the event/timestamp logic.

## Interface
- `WIDTH`, 8, word width; only 8 is supported.
- `ERROR_LIMIT`, 4, number of consecutive bad symbols while locked that forces relock.
- `COUNTER_WIDTH`, 16, width of the saturating error counter.

- `clock`  input  1  fabric word clock, same clock as the deserializer `CLKDIV`.
- `reset`  input  1  asynchronous, active-low.
- `word_in`  input  8  deserialized word; bit 7 is the earliest bit on the wire.
- `locked`  output  1  alignment acquired.
- `bit_offset`  output  3  locked bit offset k.
- `trigger`  output  1  one-cycle pulse per decoded token.
- `token`  output  2  id of the decoded token (F0=0, 81=1, 88=2, AA=3); held between pulses.
- `sync`  output  1  one-cycle pulse, coincident with `trigger` when token=0.
- `sequence_error`  output  1  one-cycle pulse; token did not match the expected id.
- `symbol_error`  output  1  one-cycle pulse; nonzero non-token symbol seen while locked.
- `error_count`  output  COUNTER_WIDTH  saturating count of sequence and symbol errors.

## Operation
- Pipeline: `d1 <= word_in`, `d2 <= d1`. For k in 0..7, `window_k` = bits [15:8] of `({d2,d1} << k)`.
- Two states: HUNT and LOCKED.
- **HUNT**
  - Any `window_k` == F0 causes lock. `bit_offset` <= k; if several k match, the lowest k wins.
  - On lock: `locked` <= 1, emit `trigger` with token 0 and `sync`, set expected token = 1, state <= LOCKED.
  - Other tokens are ignored in HUNT; no errors are counted.
- **LOCKED**: decode only `window_{bit_offset}`.
  - 00: idle; no action.
  - Token i: pulse `trigger`, drive `token`=i (`sync` too if i=0).
    - If i ≠ expected: pulse `sequence_error` and increment the count.
    - In all cases expected <= (i+1) mod 4 (resynchronize to the received token).
    - Clear the consecutive-bad counter.
  - Any other value: pulse `symbol_error`, increment the count, increment the consecutive-bad counter.
  - Consecutive-bad counter reaching ERROR_LIMIT: state <= HUNT and `locked` <= 0 on the same edge that registers the final `symbol_error`. `bit_offset` holds its last value.
- F0 appearing at a different offset while LOCKED is not a valid token. It is decoded at the locked offset only, which typically yields a symbol error.
- `error_count` saturates at all-ones; it is cleared only by reset.
- Reset (any time, including mid-token): all outputs 0, `d1`/`d2` = 0, expected = 0, state = HUNT.

## Timing
- All outputs are registered. Latency is fixed at 2 clocks, independent of k.
- If the word holding a token's MSB is captured at edge n, then `trigger`/`token`/`sync`/error pulses are valid after edge n+2.
- Back-to-back tokens in consecutive words produce `trigger` on consecutive cycles.
- Pulses are exactly one cycle wide.
- Reset deassertion is synchronized by the parent. The first decision is possible 2 edges after reset release.

## Structure
- Shared package:
  - token constants TOKEN_F0=8'hF0, TOKEN_81=8'h81, TOKEN_88=8'h88, TOKEN_AA=8'hAA, IDLE=8'h00;
  - 2-bit token-id typedef;
  - state enum {HUNT, LOCKED}.
- One sub-module, `trigger_word_aligner`:
  - inputs: `d2`, `d1`, `bit_offset`;
  - combinational;
  - outputs: the 8 windows, per-offset F0 match vector, and the decoded {valid token, id, idle, bad} for the selected offset.
- Top level holds the pipeline, FSM, expected-token register, and counters.

## Test plan
- **Aligned lock:** reset, then 00, F0, 00, 81, 00, 88, 00, AA.
  - `locked`=1 and `bit_offset`=0.
  - `trigger` with tokens 0,1,2,3 two edges after each token word.
  - `sync` only with token 0; zero errors.
- **Offset 3:** stream 00, 1E, 00 (F0 at k=3), then 10, 20 (81 at k=3).
  - `bit_offset`=3.
  - tokens 0 then 1, each 2 edges after its MSB word.
- **Sequence error:** locked, then send F0, 88.
  - `sequence_error` pulses with token 2; `error_count`=1.
  - a following AA decodes with no error.
- **Loss of lock:** locked, then four words of 5A.
  - four `symbol_error` pulses; `error_count`=4.
  - `locked`=0 on the 4th.
  - a later F0 at k=6 relocks with `bit_offset`=6.
- **Reset mid-operation:** assert reset while `trigger` is high.
  - all outputs are 0 immediately (asynchronous).
  - after release, a lone 81 gives no trigger (still HUNT).
- **Saturation:** with COUNTER_WIDTH=4, force 20 sequence errors; `error_count` holds 15.

Source files
------------

// File: rtl/serdes_trigger_word_receiver_pkg.sv
// Shared definitions for the serialized trigger-word receiver.
//   - Token byte values carried on the 8-bit link.
//   - 2-bit token id type and id constants.
//   - Receiver state enum and the debug struct that exposes it.
//   - A symbol classifier used by the aligner.
package serdes_trigger_word_receiver_pkg;

  localparam logic [7:0] TOKEN_F0 = 8'hF0;
  localparam logic [7:0] TOKEN_81 = 8'h81;
  localparam logic [7:0] TOKEN_88 = 8'h88;
  localparam logic [7:0] TOKEN_AA = 8'hAA;
  localparam logic [7:0] IDLE     = 8'h00;

  typedef logic [1:0] token_id_t;

  localparam token_id_t TID_F0 = 2'd0;
  localparam token_id_t TID_81 = 2'd1;
  localparam token_id_t TID_88 = 2'd2;
  localparam token_id_t TID_AA = 2'd3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } rx_state_t;

  // Classification of one byte at the selected offset.
  // Exactly one of valid / idle / bad is set.
  typedef struct packed {
    logic      valid;
    token_id_t id;
    logic      idle;
    logic      bad;
  } symbol_t;

  // Observation bundle for checkers: FSM state, the byte being decoded
  // at the current offset and whether it is idle.
  typedef struct packed {
    rx_state_t  state;
    logic [7:0] window;
    logic       idle;
  } debug_t;

  function automatic symbol_t decode_symbol(input logic [7:0] s);
    symbol_t r;
    r = '0;
    case (s)
      TOKEN_F0: begin r.valid = 1'b1; r.id = TID_F0; end
      TOKEN_81: begin r.valid = 1'b1; r.id = TID_81; end
      TOKEN_88: begin r.valid = 1'b1; r.id = TID_88; end
      TOKEN_AA: begin r.valid = 1'b1; r.id = TID_AA; end
      IDLE:     r.idle = 1'b1;
      default:  r.bad  = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serdes_trigger_word_receiver_aligner.sv
// trigger_word_aligner: combinational bit-offset window extractor.
// Ports:
//   d2, d1      in  8   older / newer deserialized words (bit 7 earliest)
//   bit_offset  in  3   offset whose window is decoded
//   windows     out 8x8 windows[k] = bits [15:8] of ({d2,d1} << k)
//   f0_match    out 8   f0_match[k] set when windows[k] == F0
//   sel         out     classification of windows[bit_offset]
module trigger_word_aligner
  import serdes_trigger_word_receiver_pkg::*;
(
  input  logic [7:0]      d2,
  input  logic [7:0]      d1,
  input  logic [2:0]      bit_offset,
  output logic [7:0][7:0] windows,
  output logic [7:0]      f0_match,
  output symbol_t         sel
);

  always_comb begin
    windows  = '0;
    f0_match = '0;
    for (int k = 0; k < 8; k++) begin
      // Offset k means the word boundary starts k bits into d2.
      windows[k]  = 8'(({d2, d1} << k) >> 8);
      f0_match[k] = (windows[k] == TOKEN_F0);
    end
  end

  assign sel = decode_symbol(windows[bit_offset]);

endmodule

// File: rtl/serdes_trigger_word_receiver.sv
// serdes_trigger_word_receiver: finds the word alignment of the 8-bit
// trigger-word link and decodes tokens into trigger/sync pulses.
// Ports:
//   clock           in   fabric word clock (deserializer CLKDIV)
//   reset           in   asynchronous, active-low
//   word_in         in   WIDTH deserialized word, bit 7 earliest
//   locked          out  alignment acquired
//   bit_offset      out  3  locked bit offset (held across loss of lock)
//   trigger         out  one-cycle pulse per decoded token
//   token           out  2  id of last decoded token (F0=0,81=1,88=2,AA=3)
//   sync            out  one-cycle pulse with trigger when token is F0
//   sequence_error  out  one-cycle pulse, token differed from expected id
//   symbol_error    out  one-cycle pulse, nonzero non-token while locked
//   error_count     out  COUNTER_WIDTH saturating error count
//   debug           out  FSM state and current decode window
// All outputs are registered; a token whose first word is captured at
// edge n is reported after edge n+2 regardless of offset.
module serdes_trigger_word_receiver
  import serdes_trigger_word_receiver_pkg::*;
#(
  parameter int WIDTH         = 8,   // only 8 is supported
  parameter int ERROR_LIMIT   = 4,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         word_in,
  output logic                     locked,
  output logic [2:0]               bit_offset,
  output logic                     trigger,
  output token_id_t                token,
  output logic                     sync,
  output logic                     sequence_error,
  output logic                     symbol_error,
  output logic [COUNTER_WIDTH-1:0] error_count,
  output debug_t                   debug
);

  localparam int BAD_W = (ERROR_LIMIT < 2) ? 1 : $clog2(ERROR_LIMIT + 1);

  logic [WIDTH-1:0] d1, d2;
  rx_state_t        state, state_n;
  token_id_t        expected, expected_n;
  logic [BAD_W-1:0] bad_run, bad_n;
  logic [2:0]       offset_n;
  logic             trigger_n, sync_n, seq_n, sym_n;
  token_id_t        token_n;

  logic [7:0][7:0]  windows;
  logic [7:0]       f0_match;
  symbol_t          sel;

  logic             lock_found;
  logic [2:0]       lock_k;

  trigger_word_aligner u_aligner (
    .d2         (d2),
    .d1         (d1),
    .bit_offset (bit_offset),
    .windows    (windows),
    .f0_match   (f0_match),
    .sel        (sel)
  );

  // Lowest matching offset wins: scan downward so k=0 is assigned last.
  always_comb begin
    lock_found = 1'b0;
    lock_k     = '0;
    for (int k = 7; k >= 0; k--) begin
      if (f0_match[k]) begin
        lock_found = 1'b1;
        lock_k     = 3'(k);
      end
    end
  end

  always_comb begin
    state_n    = state;
    offset_n   = bit_offset;
    expected_n = expected;
    bad_n      = bad_run;
    trigger_n  = 1'b0;
    token_n    = token;
    sync_n     = 1'b0;
    seq_n      = 1'b0;
    sym_n      = 1'b0;
    unique case (state)
      HUNT: begin
        if (lock_found) begin
          state_n    = LOCKED;
          offset_n   = lock_k;
          trigger_n  = 1'b1;
          token_n    = TID_F0;
          sync_n     = 1'b1;
          expected_n = TID_81;
          bad_n      = '0;
        end
      end
      LOCKED: begin
        if (sel.valid) begin
          trigger_n  = 1'b1;
          token_n    = sel.id;
          sync_n     = (sel.id == TID_F0);
          seq_n      = (sel.id != expected);
          // Always resynchronise to what was actually received.
          expected_n = sel.id + 2'd1;
          bad_n      = '0;
        end else if (sel.bad) begin
          sym_n = 1'b1;
          if (bad_run == BAD_W'(ERROR_LIMIT - 1)) begin
            state_n = HUNT;
            bad_n   = '0;
          end else begin
            bad_n = bad_run + BAD_W'(1);
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d1             <= '0;
      d2             <= '0;
      state          <= HUNT;
      locked         <= 1'b0;
      bit_offset     <= '0;
      expected       <= TID_F0;
      bad_run        <= '0;
      trigger        <= 1'b0;
      token          <= TID_F0;
      sync           <= 1'b0;
      sequence_error <= 1'b0;
      symbol_error   <= 1'b0;
      error_count    <= '0;
    end else begin
      d1             <= word_in;
      d2             <= d1;
      state          <= state_n;
      locked         <= (state_n == LOCKED);
      bit_offset     <= offset_n;
      expected       <= expected_n;
      bad_run        <= bad_n;
      trigger        <= trigger_n;
      token          <= token_n;
      sync           <= sync_n;
      sequence_error <= seq_n;
      symbol_error   <= sym_n;
      if ((seq_n || sym_n) && (error_count != '1)) begin
        error_count <= error_count + COUNTER_WIDTH'(1);
      end
    end
  end

  assign debug.state  = state;
  assign debug.window = windows[bit_offset];
  assign debug.idle   = sel.idle;

endmodule

// File: tb/tb_serdes_trigger_word_receiver.sv
module tb_serdes_trigger_word_receiver;
  import serdes_trigger_word_receiver_pkg::*;

  // ---------------- clock / reset / DUTs ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  word_in = 8'h00;

  logic        locked, trigger, sync, sequence_error, symbol_error;
  logic [2:0]  bit_offset;
  logic [1:0]  token;
  logic [15:0] error_count;
  debug_t      debug;

  logic        s_locked, s_trigger, s_sync, s_sequence_error, s_symbol_error;
  logic [2:0]  s_bit_offset;
  logic [1:0]  s_token;
  logic [3:0]  s_error_count;
  debug_t      s_debug;

  always #5 clock = ~clock;

  serdes_trigger_word_receiver dut (
    .clock(clock), .reset(reset), .word_in(word_in),
    .locked(locked), .bit_offset(bit_offset), .trigger(trigger), .token(token),
    .sync(sync), .sequence_error(sequence_error), .symbol_error(symbol_error),
    .error_count(error_count), .debug(debug)
  );

  serdes_trigger_word_receiver #(.COUNTER_WIDTH(4)) dut_sat (
    .clock(clock), .reset(reset), .word_in(word_in),
    .locked(s_locked), .bit_offset(s_bit_offset), .trigger(s_trigger), .token(s_token),
    .sync(s_sync), .sequence_error(s_sequence_error), .symbol_error(s_symbol_error),
    .error_count(s_error_count), .debug(s_debug)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Keeps the last two received words, computes each window arithmetically
  // and applies the token/lock rules; outputs are what should be visible
  // just after the edge.
  logic [7:0] tok_tab [4] = '{8'hF0, 8'h81, 8'h88, 8'hAA};
  logic [7:0] m_d1, m_d2;
  bit         m_locked;
  logic [2:0] m_off;
  int         m_exp, m_bad, m_cnt;
  bit         e_trig, e_sync, e_seq, e_sym;
  logic [1:0] e_tok;

  function automatic logic [7:0] win_at(input logic [15:0] p, input int k);
    logic [15:0] s;
    s = p << k;
    return s[15:8];
  endfunction

  task automatic m_reset();
    m_d1 = 0; m_d2 = 0; m_locked = 0; m_off = 0; m_exp = 0; m_bad = 0; m_cnt = 0;
    e_trig = 0; e_sync = 0; e_seq = 0; e_sym = 0; e_tok = 0;
  endtask

  task automatic model_step(input logic [7:0] w);
    logic [15:0] pair;
    logic [7:0]  win;
    int          found, id;
    pair = {m_d2, m_d1};
    e_trig = 0; e_sync = 0; e_seq = 0; e_sym = 0;
    if (!m_locked) begin
      found = -1;
      for (int k = 7; k >= 0; k--) if (win_at(pair, k) == 8'hF0) found = k;
      if (found >= 0) begin
        m_locked = 1; m_off = found[2:0]; e_trig = 1; e_tok = 0; e_sync = 1;
        m_exp = 1; m_bad = 0;
      end
    end else begin
      win = win_at(pair, int'(m_off));
      id = -1;
      for (int i = 0; i < 4; i++) if (tok_tab[i] == win) id = i;
      if (id >= 0) begin
        e_trig = 1; e_tok = id[1:0]; e_sync = (id == 0);
        if (id != m_exp) begin e_seq = 1; m_cnt++; end
        m_exp = (id + 1) % 4;
        m_bad = 0;
      end else if (win != 8'h00) begin
        e_sym = 1; m_cnt++; m_bad++;
        if (m_bad == 4) begin m_locked = 0; m_bad = 0; end
      end
    end
    m_d2 = m_d1; m_d1 = w;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [7:0] w);
    word_in = w;
    @(posedge clock);
    model_step(w);
    #1;
  endtask

  task automatic do_reset();
    word_in = 8'h00;
    reset = 1'b0;
    m_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    word_in = 8'h00;
    reset = 1'b0;
    m_reset();
    #3;
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %0b want 0", locked); end
    n_vec++; if (trigger !== 1'b0) begin n_err++; $display("FAIL reset_trigger got %0b want 0", trigger); end
    n_vec++; if (token !== 2'd0) begin n_err++; $display("FAIL reset_token got %0d want 0", token); end
    n_vec++; if (bit_offset !== 3'd0) begin n_err++; $display("FAIL reset_offset got %0d want 0", bit_offset); end
    n_vec++; if ({sync, sequence_error, symbol_error} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got %b want 000", {sync, sequence_error, symbol_error}); end
    n_vec++; if (error_count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", error_count); end
    n_vec++; if (s_error_count !== 4'd0) begin n_err++; $display("FAIL reset_count_sat got %0d want 0", s_error_count); end
    n_vec++; if (debug.state !== HUNT) begin n_err++; $display("FAIL reset_state got %0d want HUNT", debug.state); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_aligned();
    logic [7:0] stim [10] = '{8'h00, 8'hF0, 8'h00, 8'h81, 8'h00, 8'h88, 8'h00, 8'hAA, 8'h00, 8'h00};
    int exp_cyc [4] = '{3, 5, 7, 9};
    int got_cyc [$];
    logic [7:0] exp_q [$];
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 10; i++) begin
      apply(stim[i]);
      if (trigger === 1'b1) begin
        got_cyc.push_back(i);
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL aligned_extra_trigger cycle %0d token %0d", i, token); end
        else if ({6'd0, token} !== exp_q[0]) begin n_err++; $display("FAIL aligned_token got %0d want %0d", token, exp_q[0]); void'(exp_q.pop_front()); end
        else void'(exp_q.pop_front());
      end
      n_vec++; if (sync !== (i == 3)) begin n_err++; $display("FAIL aligned_sync cycle %0d got %0b", i, sync); end
      n_vec++; if ({sequence_error, symbol_error} !== 2'b00) begin n_err++; $display("FAIL aligned_errors cycle %0d got %b want 00", i, {sequence_error, symbol_error}); end
    end
    n_vec++; if (got_cyc.size() != 4) begin n_err++; $display("FAIL aligned_trigger_count got %0d want 4", got_cyc.size()); end
    else for (int j = 0; j < 4; j++) begin
      n_vec++; if (got_cyc[j] != exp_cyc[j]) begin n_err++; $display("FAIL aligned_latency got cycle %0d want %0d", got_cyc[j], exp_cyc[j]); end
    end
    n_vec++; if (locked !== 1'b1 || bit_offset !== 3'd0) begin n_err++; $display("FAIL aligned_lock got %0b/%0d want 1/0", locked, bit_offset); end
    n_vec++; if (error_count !== 16'd0) begin n_err++; $display("FAIL aligned_count got %0d want 0", error_count); end
  endtask

  task automatic test_offset3();
    logic [7:0] stim [7] = '{8'h00, 8'h1E, 8'h00, 8'h10, 8'h20, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(stim[i]);
      n_vec++; if (trigger !== (i == 3 || i == 5)) begin n_err++; $display("FAIL off3_trigger cycle %0d got %0b", i, trigger); end
      if (i == 3) begin n_vec++; if (token !== 2'd0 || sync !== 1'b1) begin n_err++; $display("FAIL off3_tok0 got %0d/%0b want 0/1", token, sync); end end
      if (i == 5) begin n_vec++; if (token !== 2'd1 || sync !== 1'b0) begin n_err++; $display("FAIL off3_tok1 got %0d/%0b want 1/0", token, sync); end end
    end
    n_vec++; if (bit_offset !== 3'd3) begin n_err++; $display("FAIL off3_offset got %0d want 3", bit_offset); end
    n_vec++; if (error_count !== 16'd0) begin n_err++; $display("FAIL off3_count got %0d want 0", error_count); end
  endtask

  task automatic test_sequence_error();
    logic [7:0] stim [6] = '{8'h00, 8'hF0, 8'h88, 8'hAA, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(stim[i]);
      n_vec++; if (trigger !== (i >= 3 && i <= 5)) begin n_err++; $display("FAIL seq_trigger cycle %0d got %0b", i, trigger); end
      n_vec++; if (sequence_error !== (i == 4)) begin n_err++; $display("FAIL seq_error cycle %0d got %0b", i, sequence_error); end
      if (i == 4) begin n_vec++; if (token !== 2'd2 || error_count !== 16'd1) begin n_err++; $display("FAIL seq_tok2 got %0d/%0d want 2/1", token, error_count); end end
      if (i == 5) begin n_vec++; if (token !== 2'd3) begin n_err++; $display("FAIL seq_tok3 got %0d want 3", token); end end
    end
    n_vec++; if (error_count !== 16'd1) begin n_err++; $display("FAIL seq_count got %0d want 1", error_count); end
  endtask

  task automatic test_loss_of_lock();
    logic [7:0] stim [12] = '{8'h00, 8'hF0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h03, 8'hC0, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(stim[i]);
      n_vec++; if (symbol_error !== (i >= 4 && i <= 7)) begin n_err++; $display("FAIL lol_symerr cycle %0d got %0b", i, symbol_error); end
      n_vec++; if (trigger !== (i == 3 || i == 10)) begin n_err++; $display("FAIL lol_trigger cycle %0d got %0b", i, trigger); end
      if (i == 6) begin n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL lol_still_locked got %0b want 1", locked); end end
      if (i == 7) begin
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL lol_unlock got %0b want 0", locked); end
        n_vec++; if (error_count !== 16'd4) begin n_err++; $display("FAIL lol_count got %0d want 4", error_count); end
        n_vec++; if (bit_offset !== 3'd0) begin n_err++; $display("FAIL lol_offset_hold got %0d want 0", bit_offset); end
      end
    end
    n_vec++; if (locked !== 1'b1 || bit_offset !== 3'd6) begin n_err++; $display("FAIL lol_relock got %0b/%0d want 1/6", locked, bit_offset); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] stim [5] = '{8'h00, 8'hF0, 8'h88, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 5; i++) apply(stim[i]);
    n_vec++; if (trigger !== 1'b1 || error_count !== 16'd1) begin n_err++; $display("FAIL mid_precond got %0b/%0d want 1/1", trigger, error_count); end
    reset = 1'b0;
    m_reset();
    #1;
    n_vec++; if ({trigger, locked, sync, sequence_error, symbol_error} !== 5'b0) begin n_err++; $display("FAIL mid_async_flags got %b want 00000", {trigger, locked, sync, sequence_error, symbol_error}); end
    n_vec++; if (token !== 2'd0 || bit_offset !== 3'd0) begin n_err++; $display("FAIL mid_async_tok got %0d/%0d want 0/0", token, bit_offset); end
    n_vec++; if (error_count !== 16'd0 || s_error_count !== 4'd0) begin n_err++; $display("FAIL mid_async_count got %0d/%0d want 0/0", error_count, s_error_count); end
    word_in = 8'h00;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    foreach (stim[i]) begin
      apply(i == 1 ? 8'h81 : 8'h00);
      n_vec++; if (trigger !== 1'b0 || locked !== 1'b0) begin n_err++; $display("FAIL mid_hunt cycle %0d got %0b/%0b want 0/0", i, trigger, locked); end
    end
  endtask

  task automatic test_back_to_back_saturation();
    int n_trig, n_seq;
    n_trig = 0; n_seq = 0;
    do_reset();
    apply(8'h00);
    apply(8'hF0);
    for (int i = 0; i < 24; i++) begin
      apply(i < 20 ? 8'h88 : 8'h00);
      if (i >= 1 && i <= 21) begin
        n_vec++; if (trigger !== 1'b1) begin n_err++; $display("FAIL b2b_trigger cycle %0d got %0b want 1", i, trigger); end
      end
      n_trig += int'(trigger);
      n_seq  += int'(sequence_error);
    end
    n_vec++; if (n_trig != 21 || n_seq != 20) begin n_err++; $display("FAIL b2b_counts got %0d/%0d want 21/20", n_trig, n_seq); end
    n_vec++; if (error_count !== 16'd20) begin n_err++; $display("FAIL sat_wide got %0d want 20", error_count); end
    n_vec++; if (s_error_count !== 4'd15) begin n_err++; $display("FAIL sat_narrow got %0d want 15", s_error_count); end
  endtask

  task automatic test_random();
    int k, r;
    logic [7:0] l, prev, w;
    logic [15:0] e16;
    logic [3:0] e4;
    for (int seg = 0; seg < 4; seg++) begin
      k = $urandom_range(0, 7);
      do_reset();
      prev = 8'h00;
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 9);
        if (r < 4) l = 8'h00;
        else if (r < 8) l = tok_tab[$urandom_range(0, 3)];
        else l = 8'($urandom_range(0, 255));
        // Logical byte stream delayed by k bits on the wire.
        w = 8'({prev, l} >> k);
        prev = l;
        apply(w);
        e16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        e4  = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
        n_vec++;
        if ({trigger, token, sync, sequence_error, symbol_error, locked, bit_offset, error_count} !==
            {e_trig, e_tok, e_sync, e_seq, e_sym, m_locked, m_off, e16}) begin
          n_err++;
          $display("FAIL rand seg %0d k %0d cycle %0d got trig %0b tok %0d sync %0b seq %0b sym %0b lock %0b off %0d cnt %0d want %0b %0d %0b %0b %0b %0b %0d %0d",
                   seg, k, i, trigger, token, sync, sequence_error, symbol_error, locked, bit_offset, error_count,
                   e_trig, e_tok, e_sync, e_seq, e_sym, m_locked, m_off, e16);
        end
        n_vec++; if (s_error_count !== e4) begin n_err++; $display("FAIL rand_sat cycle %0d got %0d want %0d", i, s_error_count, e4); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_aligned();
    test_offset3();
    test_sequence_error();
    test_loss_of_lock();
    test_reset_mid();
    test_back_to_back_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
